tow_match_ctrl: RTL and testbench
=================================

# tow_match_ctrl

Match controller for the tug-of-war game. It turns two player button inputs into moves of a 9-position light, detects round wins, and issues one-cycle increment pulses to the two per-player saturating win counters (0..7). It reads those counters back to decide when the match is over. It sits between the synchronized button inputs and the two score counters / LED outputs.

## Interface
Parameters:
- WIN_SCORE, 7: score a player must reach to win the match (1..7)
- HOLD_CYCLES, 4: cycles the playfield stays dark after a round win (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- p1_btn  in  1  player 1 button level, already synchronized; pushes light toward index 8
- p2_btn  in  1  player 2 button level, already synchronized; pushes light toward index 0
- p1_score  in  3  current player 1 counter value
- p2_score  in  3  current player 2 counter value
- leds  out  9  playfield, one-hot light position or all-off
- p1_win_inc  out  1  one-cycle increment pulse to player 1 counter
- p2_win_inc  out  1  one-cycle increment pulse to player 2 counter
- match_over  out  1  high once a player reaches WIN_SCORE
- winner  out  2  01 = player 1, 10 = player 2, 00 = none

## Operation
- States: PLAY, ROUND_END, MATCH_OVER.
- Edge detect per player, using a registered previous level (p*_q):
  - press_k = p*_btn & ~p*_q.
  - p*_q updates every cycle in every state, so a button held across a state change never counts as a press.
- PLAY:
  - pos (0..8) drives leds = 1 << pos.
  - Both presses in the same cycle: no move.
  - p1 press only, pos < 8: pos + 1.
  - p1 press only, pos == 8: player 1 wins the round.
  - p2 press only, pos > 0: pos − 1.
  - p2 press only, pos == 0: player 2 wins the round.
- Round win by player k:
  - Pulse pk_win_inc for exactly one cycle.
  - If pk_score == WIN_SCORE−1 (pre-increment value), go to MATCH_OVER. Otherwise go to ROUND_END.
- ROUND_END:
  - leds = 0. Presses are ignored.
  - The hold counter runs HOLD_CYCLES cycles, then the block returns to PLAY with pos = 4.
- MATCH_OVER:
  - Terminal until reset.
  - match_over = 1, winner set, leds = winner's edge light only (bit 8 for player 1, bit 0 for player 2).
  - No further increment pulses. Presses ignored.
- Never assert both win_inc outputs in the same cycle.

## Timing
- All outputs are registered.
- Reset values: state PLAY, pos 4, leds 9'b000010000, p1_win_inc 0, p2_win_inc 0, match_over 0, winner 00, p1_q 0, p2_q 0, hold counter 0.
- Reset mid-round or mid-hold returns to these values on the next edge.
- The score counters share the same reset.
- Latency:
  - A rising edge on a button input that is sampled at clock edge n updates leds at edge n, so the change is visible in cycle n+1.
  - A win pulse is high in the cycle after the winning press is sampled.
  - ROUND_END (leds 0) begins in that same cycle.
- ROUND_END occupies exactly HOLD_CYCLES cycles. pos = 4 is visible in the following cycle.
- MATCH_OVER outputs appear in the same cycle as the final win pulse.
- p*_score is sampled only in the win cycle. The counters update one cycle after the pulse, so the pre-increment comparison is required.

## Test plan
- Reset: assert reset 2 cycles -> leds 000010000, match_over 0, winner 00, no pulses.
- Walk and win: 4 p1 presses (1-cycle high, 1-cycle low) -> leds bit 8. 5th press -> p1_win_inc high exactly 1 cycle, leds 0 for 4 cycles, then leds 000010000.
- Simultaneous and held presses:
  - Both buttons rise in the same cycle -> pos unchanged.
  - p2 held high for 10 cycles -> exactly one move (leds 000001000).
- Held through round end: p1 holds the button from its winning press through ROUND_END -> no move after return to PLAY until the button is released and pressed again.
- Match win: p2_score driven to 6, p2 wins a round -> p2_win_inc 1 cycle, match_over 1, winner 10, leds 000000001. Further presses -> no change, no pulses.
- Reset during ROUND_END (2nd hold cycle) -> next cycle leds 000010000, state PLAY, hold counter cleared.

Source files
------------

// File: rtl/tow_match_if.sv
// Signal bundle between the synchronized button/score side and the
// tug-of-war match controller.
//
// Signalling: there is no valid/ready handshake on this bundle. Buttons are
// levels sampled every clock, scores are levels read by the controller, and
// the win increments are single-cycle pulses that the counters take
// unconditionally on the edge that ends the pulse cycle.
interface tow_match_if;
  logic       p1_btn;
  logic       p2_btn;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [8:0] leds;
  logic       p1_win_inc;
  logic       p2_win_inc;
  logic       match_over;
  logic [1:0] winner;
  logic [1:0] state_dbg;

  // Environment side: drives buttons and score readback, observes outputs.
  modport master (
    output p1_btn, p2_btn, p1_score, p2_score,
    input  leds, p1_win_inc, p2_win_inc, match_over, winner, state_dbg
  );

  // Controller side.
  modport slave (
    input  p1_btn, p2_btn, p1_score, p2_score,
    output leds, p1_win_inc, p2_win_inc, match_over, winner, state_dbg
  );
endinterface

// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: moves a one-hot light with button presses,
// detects round wins, pulses the per-player win counters and ends the match
// once a player's pre-increment score shows the winning round.
module tow_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  tow_match_if.slave  bus
);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_END  = 2'd1,
    MATCH_OVER = 2'd2
  } state_e;

  localparam int             HW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  // Counters update one cycle after the pulse, so compare the old value.
  localparam logic [2:0]     SCORE_LAST = 3'(WIN_SCORE - 1);
  localparam logic [3:0]     POS_MID    = 4'd4;
  localparam logic [3:0]     POS_TOP    = 4'd8;

  state_e        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          p1_q, p2_q;
  logic [8:0]    leds_q, leds_d;
  logic          p1_inc_q, p1_inc_d;
  logic          p2_inc_q, p2_inc_d;
  logic          match_over_q, match_over_d;
  logic [1:0]    winner_q, winner_d;

  logic press1, press2;

  // A press is a rising edge against last cycle's level; the level register
  // runs in every state so a button held across a state change is not a press.
  assign press1 = bus.p1_btn & ~p1_q;
  assign press2 = bus.p2_btn & ~p2_q;

  // Next-state, light position, hold count and registered output values.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    hold_d       = hold_q;
    p1_inc_d     = 1'b0;
    p2_inc_d     = 1'b0;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    leds_d       = leds_q;

    case (state_q)
      PLAY: begin
        if (press1 && !press2) begin
          if (pos_q == POS_TOP) begin
            p1_inc_d = 1'b1;
            hold_d   = '0;
            if (bus.p1_score == SCORE_LAST) begin
              state_d      = MATCH_OVER;
              match_over_d = 1'b1;
              winner_d     = 2'b01;
            end else begin
              state_d = ROUND_END;
            end
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else if (press2 && !press1) begin
          if (pos_q == 4'd0) begin
            p2_inc_d = 1'b1;
            hold_d   = '0;
            if (bus.p2_score == SCORE_LAST) begin
              state_d      = MATCH_OVER;
              match_over_d = 1'b1;
              winner_d     = 2'b10;
            end else begin
              state_d = ROUND_END;
            end
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end
      end
      ROUND_END: begin
        if (hold_q == HOLD_LAST) begin
          state_d = PLAY;
          pos_d   = POS_MID;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      MATCH_OVER: begin
        // Terminal until reset.
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_MID;
        hold_d  = '0;
      end
    endcase

    // The light reflects the state being entered, so it changes on the same
    // edge that samples the press.
    case (state_d)
      PLAY:       leds_d = 9'd1 << pos_d;
      ROUND_END:  leds_d = '0;
      MATCH_OVER: leds_d = (winner_d == 2'b01) ? 9'h100 : 9'h001;
      default:    leds_d = '0;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLAY;
      pos_q        <= POS_MID;
      hold_q       <= '0;
      p1_q         <= 1'b0;
      p2_q         <= 1'b0;
      leds_q       <= 9'b000010000;
      p1_inc_q     <= 1'b0;
      p2_inc_q     <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hold_q       <= hold_d;
      p1_q         <= bus.p1_btn;
      p2_q         <= bus.p2_btn;
      leds_q       <= leds_d;
      p1_inc_q     <= p1_inc_d;
      p2_inc_q     <= p2_inc_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.p1_win_inc = p1_inc_q;
  assign bus.p2_win_inc = p2_inc_q;
  assign bus.match_over = match_over_q;
  assign bus.winner     = winner_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Bench for tow_match_ctrl: table of per-cycle vectors plus a hand-written
// match-win sequence with a bounded wait.
module tb_tow_match_ctrl;

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_RE   = 2'd1;
  localparam logic [1:0] ST_MO   = 2'd2;

  logic clk;
  logic reset;

  tow_match_if bus ();

  tow_match_ctrl #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       p1;
    logic       p2;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [8:0] leds;
    logic       i1;
    logic       i2;
    logic       mo;
    logic [1:0] win;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input logic r, input logic p1, input logic p2,
                                  input logic [2:0] s1, input logic [2:0] s2,
                                  input logic [8:0] leds, input logic i1,
                                  input logic i2, input logic mo,
                                  input logic [1:0] win, input logic [1:0] st);
    vec_t v;
    v.rst = r;  v.p1 = p1; v.p2 = p2; v.s1 = s1; v.s2 = s2;
    v.leds = leds; v.i1 = i1; v.i2 = i2; v.mo = mo; v.win = win; v.st = st;
    tbl.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_out(input string name);
    logic [15:0] exp_v, act_v;
    exp_v = exp_q.pop_front();
    act_v = {bus.leds, bus.p1_win_inc, bus.p2_win_inc, bus.match_over,
             bus.winner, bus.state_dbg};
    n_vec++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got leds=%b inc1=%b inc2=%b mo=%b win=%b st=%0d, want leds=%b inc1=%b inc2=%b mo=%b win=%b st=%0d",
               name, act_v[15:7], act_v[6], act_v[5], act_v[4], act_v[3:2], act_v[1:0],
               exp_v[15:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:2], exp_v[1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic p1, input logic p2,
                       input logic [2:0] s1, input logic [2:0] s2);
    @(negedge clk);
    reset        = r;
    bus.p1_btn   = p1;
    bus.p2_btn   = p2;
    bus.p1_score = s1;
    bus.p2_score = s2;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int presses;
    logic seen;

    reset        = 1'b1;
    bus.p1_btn   = 1'b0;
    bus.p2_btn   = 1'b0;
    bus.p1_score = 3'd0;
    bus.p2_score = 3'd0;

    // Reset for two cycles.
    for (int k = 0; k < 2; k++) add_vec(1, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);

    // Walk player 1 to the top edge, win the round, hold dark 4 cycles.
    for (int k = 0; k < 4; k++) begin
      add_vec(0, 1, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
      add_vec(0, 0, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
    end
    add_vec(0, 1, 0, 0, 0, 9'h000, 1, 0, 0, 2'b00, ST_RE);
    for (int k = 0; k < 3; k++) add_vec(0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 2'b00, ST_RE);
    add_vec(0, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);

    // Simultaneous press: no move. Then p2 held 10 cycles: one move.
    add_vec(0, 1, 1, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);
    add_vec(0, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);
    for (int k = 0; k < 10; k++) add_vec(0, 0, 1, 0, 0, 9'h008, 0, 0, 0, 2'b00, ST_PLAY);
    add_vec(0, 0, 0, 0, 0, 9'h008, 0, 0, 0, 2'b00, ST_PLAY);

    // From pos 3 walk p1 to 8, then hold the winning press through the hold.
    for (int k = 0; k < 5; k++) begin
      add_vec(0, 1, 0, 0, 0, 9'h010 << k, 0, 0, 0, 2'b00, ST_PLAY);
      add_vec(0, 0, 0, 0, 0, 9'h010 << k, 0, 0, 0, 2'b00, ST_PLAY);
    end
    add_vec(0, 1, 0, 0, 0, 9'h000, 1, 0, 0, 2'b00, ST_RE);
    for (int k = 0; k < 3; k++) add_vec(0, 1, 0, 0, 0, 9'h000, 0, 0, 0, 2'b00, ST_RE);
    for (int k = 0; k < 3; k++) add_vec(0, 1, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);
    add_vec(0, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);
    add_vec(0, 1, 0, 0, 0, 9'h020, 0, 0, 0, 2'b00, ST_PLAY);
    add_vec(0, 0, 0, 0, 6, 9'h020, 0, 0, 0, 2'b00, ST_PLAY);

    // p2 at score 6 walks from pos 5 to 0 and wins the match.
    for (int k = 0; k < 5; k++) begin
      add_vec(0, 0, 1, 0, 6, 9'h010 >> k, 0, 0, 0, 2'b00, ST_PLAY);
      add_vec(0, 0, 0, 0, 6, 9'h010 >> k, 0, 0, 0, 2'b00, ST_PLAY);
    end
    add_vec(0, 0, 1, 0, 6, 9'h001, 0, 1, 1, 2'b10, ST_MO);
    add_vec(0, 0, 0, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);
    add_vec(0, 1, 0, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);
    add_vec(0, 0, 0, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);
    add_vec(0, 0, 1, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);
    add_vec(0, 1, 1, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);
    add_vec(0, 0, 0, 0, 6, 9'h001, 0, 0, 1, 2'b10, ST_MO);

    // Reset out of MATCH_OVER, win a round, reset in the 2nd hold cycle.
    add_vec(1, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);
    for (int k = 0; k < 4; k++) begin
      add_vec(0, 1, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
      add_vec(0, 0, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
    end
    add_vec(0, 1, 0, 0, 0, 9'h000, 1, 0, 0, 2'b00, ST_RE);
    add_vec(0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 2'b00, ST_RE);
    add_vec(1, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);

    // Another round win must again hold exactly 4 cycles (hold count cleared).
    for (int k = 0; k < 4; k++) begin
      add_vec(0, 1, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
      add_vec(0, 0, 0, 0, 0, 9'h020 << k, 0, 0, 0, 2'b00, ST_PLAY);
    end
    add_vec(0, 1, 0, 0, 0, 9'h000, 1, 0, 0, 2'b00, ST_RE);
    for (int k = 0; k < 3; k++) add_vec(0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 2'b00, ST_RE);
    add_vec(0, 0, 0, 0, 0, 9'h010, 0, 0, 0, 2'b00, ST_PLAY);

    // Apply the table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].p1, tbl[i].p2, tbl[i].s1, tbl[i].s2);
      exp_q.push_back({tbl[i].leds, tbl[i].i1, tbl[i].i2, tbl[i].mo,
                       tbl[i].win, tbl[i].st});
      settle();
      check_out($sformatf("vec%0d", i));
    end

    // Hand-written: player 1 at score 6 presses until a win pulse appears.
    drive(1, 0, 0, 0, 0);
    exp_q.push_back({9'h010, 1'b0, 1'b0, 1'b0, 2'b00, ST_PLAY});
    settle();
    check_out("p1_match_reset");

    presses = 0;
    seen    = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(0, 1, 0, 6, 0);
      settle();
      presses++;
      if (bus.p1_win_inc) begin
        seen = 1'b1;
      end else begin
        drive(0, 0, 0, 6, 0);
        settle();
      end
    end
    n_vec++;
    if (!seen || presses != 5) begin
      n_fail++;
      $display("FAIL p1_match_presses: got seen=%b presses=%0d, want seen=1 presses=5",
               seen, presses);
    end

    exp_q.push_back({9'h100, 1'b1, 1'b0, 1'b1, 2'b01, ST_MO});
    check_out("p1_match_win");

    drive(0, 0, 0, 6, 0);
    exp_q.push_back({9'h100, 1'b0, 1'b0, 1'b1, 2'b01, ST_MO});
    settle();
    check_out("p1_match_after");

    drive(0, 0, 1, 6, 0);
    exp_q.push_back({9'h100, 1'b0, 1'b0, 1'b1, 2'b01, ST_MO});
    settle();
    check_out("p1_match_ignore");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
